serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the existing 1-bit full adder cell. It accepts a parallel operand pair on a start pulse and feeds one bit per clock, LSB first, through a single `full_adder_1b`. A registered carry links consecutive bits, and the completed sum/carry is presented in parallel with a one-cycle done strobe. This is the area-minimal alternative to a ripple-carry chain and the natural next stage above the 1-bit cell.

---
 rtl/adder_pkg.sv | 9 +
 rtl/serial_adder_if.sv | 13 +
 rtl/full_adder_1b.sv | 11 +
 rtl/serial_adder.sv | 70 +++++++
 tb/tb_serial_adder.sv | 127 ++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state encoding and default width for the serial adder
package adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand request and result bundle between requester and serial adder
interface serial_adder_if import adder_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder_1b.sv
// full_adder_1b: single-bit full adder cell
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock LSB first through one full adder
module serial_adder import adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_s, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_busy, r_done, r_cout;
  logic             w_s, w_co, w_last;
  logic [WIDTH-1:0] w_sum_next;
  full_adder_1b u_fa (.a(r_a[0]), .b(r_b[0]), .cin(r_c), .s(w_s), .cout(w_co));
  // shift form keeps WIDTH=1 legal without a reversed slice
  assign w_sum_next = (r_s >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  assign w_last     = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_s   <= w_sum_next;
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_sum_next;
            r_cout  <= w_co;
          end
        end
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_c     <= bus.cin;
            r_cnt   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder (WIDTH=8 and WIDTH=1) against a+b+cin
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [8:0] prev = '0;
  serial_adder_if #(.WIDTH(8)) bus  ();
  serial_adder_if #(.WIDTH(1)) bus1 ();
  serial_adder #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int inj);
    logic [8:0] exp;
    exp = 9'(x) + 9'(y) + 9'(c);
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = c;
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus.start = (i == inj);
      bus.a = (i == inj) ? 8'h10 : 8'($urandom);
      bus.b = (i == inj) ? 8'h20 : 8'($urandom);
      bus.cin = 1'($urandom);
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done", 32'(bus.done), 32'd0);
      chk("run_hold", 32'({bus.cout, bus.sum}), 32'(prev));
      tick();
    end
    bus.start = 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("result", 32'({bus.cout, bus.sum}), 32'(exp));
    prev = exp;
    tick();
    chk("after_done", 32'(bus.done), 32'd0);
    chk("after_busy", 32'(bus.busy), 32'd0);
    chk("after_hold", 32'({bus.cout, bus.sum}), 32'(exp));
  endtask
  initial begin
    logic [8:0] e;
    logic [1:0] e1;
    bus.start = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
    bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'({bus.cout, bus.sum}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    op8(8'h5A, 8'h3C, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    op8(8'h01, 8'h02, 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_second_done", 32'(bus.done), 32'd0);
      chk("no_second_busy", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
    tick();
    bus.a = 8'h80; bus.b = 8'h80;
    for (int c = 1; c <= 18; c++) begin
      if (c == 9 || c == 18) begin
        e = (c == 9) ? 9'h033 : 9'h100;
        if (c == 18) bus.start = 1'b0;
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_result", 32'({bus.cout, bus.sum}), 32'(e));
      end else begin
        e = (c < 9) ? prev : 9'h033;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_hold", 32'({bus.cout, bus.sum}), 32'(e));
      end
      tick();
    end
    prev = 9'h100;
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h66; bus.cin = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'({bus.cout, bus.sum}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    prev = '0;
    op8(8'h7F, 8'h01, 1'b0, 0);
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    tick();
    chk("rst_beats_start", 32'(bus.busy), 32'd0);
    prev = '0;
    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), (i % 3 == 0) ? int'($urandom_range(1, 8)) : 0);
    for (int v = 0; v < 8; v++) begin
      e1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      bus1.start = 1'b1; bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0];
      tick();
      bus1.start = 1'b0;
      chk("w1_busy", 32'(bus1.busy), 32'd1);
      chk("w1_early_done", 32'(bus1.done), 32'd0);
      tick();
      chk("w1_done", 32'(bus1.done), 32'd1);
      chk("w1_result", 32'({bus1.cout, bus1.sum}), 32'(e1));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
